// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: shared access-width type and the memory port interface used by mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    MAW_BYTE = 2'd0,
    MAW_HALF = 2'd1,
    MAW_WORD = 2'd2
  } memory_access_width_t;
endpackage

interface memory_port;
  import mem_arbiter_pkg::*;
  logic                 valid;
  logic                 we;
  logic [31:0]          addr;
  memory_access_width_t width;
  logic [31:0]          data_wr;
  logic [31:0]          data_rd;
  modport datapath (output valid, we, addr, width, data_wr, input data_rd);
  modport memory (input valid, we, addr, width, data_wr, output data_rd);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-outstanding arbiter sharing one memory port between fetch and data requesters
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY    = 1,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [31:0]          if_addr,
  output logic                 if_ack,
  output logic                 if_rvalid,
  output logic [31:0]          if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [31:0]          d_addr,
  input  memory_access_width_t d_width,
  input  logic [31:0]          d_wdata,
  output logic                 d_ack,
  output logic                 d_rvalid,
  output logic [31:0]          d_rdata,
  memory_port.datapath         mem
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t               r_state, w_next;
  logic [3:0]           r_burst_cnt;
  logic [3:0]           r_wait_cnt;
  logic                 r_owner_d;
  logic                 r_we;
  logic [31:0]          r_addr;
  memory_access_width_t r_width;
  logic [31:0]          r_wdata;
  logic                 w_idle;
  logic                 w_grant_d;
  logic                 w_resp;
  assign w_idle    = (r_state == IDLE);
  // Fetch only pre-empts data once data has taken MAX_DATA_BURST grants in a row while fetch waited
  assign w_grant_d = d_req & ~(if_req & (r_burst_cnt >= 4'(MAX_DATA_BURST)));
  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (if_req | d_req) ? ISSUE : IDLE;
      ISSUE:   w_next = (MEM_LATENCY == 1) ? RESP : WAIT;
      WAIT:    w_next = (r_wait_cnt == 4'd1) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  // Outputs; everything combinational is gated by rst_n so reset holds outputs quiet immediately
  always_comb begin
    w_resp      = rst_n & (r_state == RESP);
    d_ack       = rst_n & w_idle & w_grant_d;
    if_ack      = rst_n & w_idle & if_req & ~w_grant_d;
    if_rvalid   = w_resp & ~r_owner_d;
    d_rvalid    = w_resp & r_owner_d;
    if_rdata    = if_rvalid ? mem.data_rd : '0;
    d_rdata     = (d_rvalid & ~r_we) ? mem.data_rd : '0;
    mem.valid   = rst_n & (r_state == ISSUE);
    mem.we      = r_we;
    mem.addr    = r_addr;
    mem.width   = r_width;
    mem.data_wr = r_wdata;
  end
  // Payload capture on grant, burst accounting and latency countdown
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner_d   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_width     <= memory_access_width_t'(0);
      r_wdata     <= '0;
      r_burst_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      if (w_idle & (if_req | d_req)) begin
        r_owner_d   <= w_grant_d;
        r_we        <= w_grant_d & d_we;
        r_addr      <= w_grant_d ? d_addr : if_addr;
        r_width     <= w_grant_d ? d_width : MAW_WORD;
        r_wdata     <= w_grant_d ? d_wdata : '0;
        r_burst_cnt <= !(w_grant_d & if_req) ? 4'd0 :
                       (r_burst_cnt >= 4'(MAX_DATA_BURST)) ? 4'(MAX_DATA_BURST) : r_burst_cnt + 4'd1;
      end
      r_wait_cnt <= (r_state == ISSUE) ? 4'(MEM_LATENCY - 1) :
                    (r_state == WAIT)  ? r_wait_cnt - 4'd1 : r_wait_cnt;
    end
  end
endmodule
